// File: rtl/bcrypt_host_if_if.sv
// Host-side job stream: inbound job words and outbound result words, each with valid/ready.
interface bcrypt_host_if_if;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
   modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/bcrypt_host_if.sv
// Host sequencer for the bcrypt loop core: loads P/key/salt/cost and S BRAMs, runs the core,
// then streams P (and optionally S) back out. Owns BRAM port A whenever start is low.
module bcrypt_host_if #(
   parameter int unsigned P_WORDS    = 18,
   parameter int unsigned EXP_WORDS  = 18,
   parameter int unsigned SALT_WORDS = 4,
   parameter int unsigned S_WORDS    = 1024,
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned UNLOAD_S   = 1
) (
   input  logic            clk,
   input  logic            rst,
   bcrypt_host_if_if.slave host,
   output logic            wea,
   output logic            web,
   output logic [5:0]      addra,
   output logic [5:0]      addrb,
   output logic [31:0]     dina,
   output logic [31:0]     dinb,
   input  logic [31:0]     douta,
   output logic            weaS,
   output logic            webS,
   output logic [9:0]      addraS,
   output logic [9:0]      addrbS,
   output logic [31:0]     dinaS,
   output logic [31:0]     dinbS,
   input  logic [31:0]     doutaS,
   output logic            start,
   input  logic            done,
   output logic            busy,
   output logic [31:0]     cycles
);

   localparam int unsigned K_W    = $clog2(S_WORDS);
   localparam int unsigned P_LAST = P_WORDS + EXP_WORDS + SALT_WORDS;
   localparam int unsigned LAT_W  = $clog2(RD_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_P, S_LOAD_S, S_RUN, S_DRAIN, S_UNLOAD_P, S_UNLOAD_S
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [K_W-1:0]   r_k, w_k_nxt;
   logic [LAT_W-1:0] r_lat, w_lat_nxt;
   logic             r_pend, w_pend_nxt;
   logic             r_in_ready, w_in_ready_nxt;
   logic             r_out_valid, w_out_valid_nxt;
   logic [31:0]      r_out_data, w_out_data_nxt;
   logic             r_start, w_start_nxt;
   logic             r_busy, w_busy_nxt;
   logic [31:0]      r_cycles, w_cycles_nxt;
   logic             w_in_acc, w_out_acc, w_wr_p, w_wr_s, w_last;
   logic [31:0]      w_dout;

   // Next-state and next-output logic; r_k is the load address and also the unload read address.
   always_comb begin
      w_state_nxt     = r_state;
      w_k_nxt         = r_k;
      w_lat_nxt       = r_lat;
      w_pend_nxt      = r_pend;
      w_out_valid_nxt = r_out_valid;
      w_out_data_nxt  = r_out_data;
      w_cycles_nxt    = r_cycles;
      w_wr_p          = 1'b0;
      w_wr_s          = 1'b0;
      w_in_acc        = host.in_valid && r_in_ready && !rst;
      w_out_acc       = r_out_valid && host.out_ready;
      w_last          = (r_state == S_UNLOAD_P) ? (r_k == K_W'(P_WORDS - 1))
                                                : (r_k == K_W'(S_WORDS - 1));
      w_dout          = (r_state == S_UNLOAD_P) ? douta : doutaS;

      case (r_state)
         S_IDLE, S_LOAD_P: begin
            if (w_in_acc) begin
               w_wr_p = 1'b1;
               if (r_k == K_W'(P_LAST)) begin
                  w_state_nxt = S_LOAD_S;
                  w_k_nxt     = '0;
               end else begin
                  w_state_nxt = S_LOAD_P;
                  w_k_nxt     = r_k + K_W'(1);
               end
            end
         end
         S_LOAD_S: begin
            if (w_in_acc) begin
               w_wr_s = 1'b1;
               if (r_k == K_W'(S_WORDS - 1)) begin
                  w_state_nxt  = S_RUN;
                  w_k_nxt      = '0;
                  w_cycles_nxt = '0;
               end else begin
                  w_k_nxt = r_k + K_W'(1);
               end
            end
         end
         S_RUN: begin
            if (r_cycles != '1) w_cycles_nxt = r_cycles + 32'd1;
            if (done) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            w_state_nxt = S_UNLOAD_P;
            w_k_nxt     = '0;
            w_lat_nxt   = '0;
            w_pend_nxt  = 1'b1;
         end
         S_UNLOAD_P, S_UNLOAD_S: begin
            if (w_out_acc) w_out_valid_nxt = 1'b0;
            if (r_lat != LAT_W'(RD_LAT)) w_lat_nxt = r_lat + LAT_W'(1);
            // Capture once the read has settled and the output slot is free (or freeing now);
            // the next read is issued on the same edge so only one is ever in flight.
            if (r_pend && (r_lat == LAT_W'(RD_LAT)) && (!r_out_valid || host.out_ready)) begin
               w_out_data_nxt  = w_dout;
               w_out_valid_nxt = 1'b1;
               w_pend_nxt      = 1'b0;
               if (!w_last) begin
                  w_k_nxt    = r_k + K_W'(1);
                  w_lat_nxt  = '0;
                  w_pend_nxt = 1'b1;
               end
            end else if (!r_pend && w_last && w_out_acc) begin
               w_k_nxt   = '0;
               w_lat_nxt = '0;
               if ((r_state == S_UNLOAD_P) && (UNLOAD_S != 0)) begin
                  w_state_nxt = S_UNLOAD_S;
                  w_pend_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_in_ready_nxt = w_state_nxt inside {S_IDLE, S_LOAD_P, S_LOAD_S};
      w_start_nxt    = (w_state_nxt == S_RUN);
      w_busy_nxt     = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_lat       <= '0;
         r_pend      <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_start     <= 1'b0;
         r_busy      <= 1'b0;
         r_cycles    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_k         <= w_k_nxt;
         r_lat       <= w_lat_nxt;
         r_pend      <= w_pend_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_data  <= w_out_data_nxt;
         r_start     <= w_start_nxt;
         r_busy      <= w_busy_nxt;
         r_cycles    <= w_cycles_nxt;
      end
   end

   // Writes land in the accepting cycle so the final S write completes before start rises.
   assign wea    = w_wr_p;
   assign addra  = 6'(r_k);
   assign dina   = w_wr_p ? host.in_data : 32'd0;
   assign weaS   = w_wr_s;
   assign addraS = 10'(r_k);
   assign dinaS  = w_wr_s ? host.in_data : 32'd0;

   assign web    = 1'b0;
   assign addrb  = '0;
   assign dinb   = '0;
   assign webS   = 1'b0;
   assign addrbS = '0;
   assign dinbS  = '0;

   assign host.in_ready  = r_in_ready;
   assign host.out_valid = r_out_valid;
   assign host.out_data  = r_out_data;
   assign start          = r_start;
   assign busy           = r_busy;
   assign cycles         = r_cycles;

endmodule

// File: tb/tb_bcrypt_host_if.sv
// Bench for bcrypt_host_if: two instances (unload P+S, unload P only) with BRAM and core models.
module tb_bcrypt_host_if;

   localparam int NI = 2;
   localparam int NJOB = 41 + 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] in_data [NI];
   logic        in_valid [NI];
   logic        in_ready [NI];
   logic [31:0] out_data [NI];
   logic        out_valid [NI];
   logic        out_ready [NI];
   logic        wea [NI], web [NI], weas [NI], webs [NI];
   logic [5:0]  addra [NI], addrb [NI];
   logic [9:0]  addras [NI], addrbs [NI];
   logic [31:0] dina [NI], dinb [NI], dinas [NI], dinbs [NI];
   logic [31:0] douta [NI], doutas [NI], pd1 [NI], sd1 [NI];
   logic        start [NI], done [NI], busy [NI];
   logic [31:0] cycles [NI];
   logic [31:0] pmem [NI][64];
   logic [31:0] smem [NI][1024];
   int          run_cnt [NI] = '{0, 0};
   int          done_at [NI] = '{50, 1};
   logic        junk_done = 1'b0;

   logic [31:0] jp [41];
   logic [31:0] js [1024];
   logic [31:0] exp_q [$];
   int          n_vec = 0;
   int          n_err = 0;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      bcrypt_host_if_if hif ();
      assign hif.in_data   = in_data[g];
      assign hif.in_valid  = in_valid[g];
      assign hif.out_ready = out_ready[g];
      assign in_ready[g]   = hif.in_ready;
      assign out_data[g]   = hif.out_data;
      assign out_valid[g]  = hif.out_valid;

      bcrypt_host_if #(.UNLOAD_S(g == 0 ? 1 : 0)) u_dut (
         .clk(clk), .rst(rst), .host(hif),
         .wea(wea[g]), .web(web[g]), .addra(addra[g]), .addrb(addrb[g]),
         .dina(dina[g]), .dinb(dinb[g]), .douta(douta[g]),
         .weaS(weas[g]), .webS(webs[g]), .addraS(addras[g]), .addrbS(addrbs[g]),
         .dinaS(dinas[g]), .dinbS(dinbs[g]), .doutaS(doutas[g]),
         .start(start[g]), .done(done[g]), .busy(busy[g]), .cycles(cycles[g])
      );

      // Core model: done after done_at RUN cycles; junk done pulses while idle must be ignored.
      assign done[g] = start[g] ? (run_cnt[g] == done_at[g] - 1) : junk_done;

      // BRAMs with 2-cycle read latency; the core owns them while start is high.
      always @(posedge clk) begin
         run_cnt[g] <= start[g] ? run_cnt[g] + 1 : 0;
         pd1[g]     <= pmem[g][addra[g]];
         douta[g]   <= pd1[g];
         sd1[g]     <= smem[g][addras[g]];
         doutas[g]  <= sd1[g];
         if (start[g]) begin
            if (done[g]) begin
               for (int i = 0; i < 64; i++)   pmem[g][i] <= pmem[g][i] + 32'd1;
               for (int i = 0; i < 1024; i++) smem[g][i] <= smem[g][i] + 32'd1;
            end
         end else begin
            if (wea[g])  pmem[g][addra[g]]  <= dina[g];
            if (weas[g]) smem[g][addras[g]] <= dinas[g];
         end
      end
   end

   always @(negedge clk) junk_done = 1'($urandom_range(0, 1));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] job_word(input int idx);
      return (idx < 41) ? jp[idx] : js[idx - 41];
   endfunction

   function automatic void make_job(input bit pattern);
      for (int i = 0; i < 41; i++) begin
         if (!pattern)    jp[i] = $urandom;
         else if (i < 18) jp[i] = 32'(i);
         else if (i < 36) jp[i] = 32'h100 + 32'(i - 18);
         else if (i < 40) jp[i] = 32'hA0 + 32'(i - 36);
         else             jp[i] = 32'd0;
      end
      for (int j = 0; j < 1024; j++) js[j] = pattern ? 32'(j) : $urandom;
   endfunction

   // Expected stream: every word incremented once by the core, ascending address order.
   function automatic void build_exp(input bit with_s);
      exp_q.delete();
      for (int i = 0; i < 18; i++) exp_q.push_back(jp[i] + 32'd1);
      if (with_s) for (int j = 0; j < 1024; j++) exp_q.push_back(js[j] + 32'd1);
   endfunction

   task automatic check_quiet(input int inst, input string tag);
      check_val({tag, "_start"}, 32'(start[inst]), 0);
      check_val({tag, "_in_ready"}, 32'(in_ready[inst]), 0);
      check_val({tag, "_wea"}, 32'(wea[inst]), 0);
      check_val({tag, "_weaS"}, 32'(weas[inst]), 0);
      check_val({tag, "_busy"}, 32'(busy[inst]), 0);
   endtask

   // mode 0: random gaps; mode 1: in_valid alternates with junk data on idle cycles.
   task automatic load_job(input int inst, input int mode, input int abort_at);
      int  idx = 0;
      int  t = 0;
      bit  gate;
      while (idx < NJOB && t < 6000) begin
         @(negedge clk);
         if (abort_at >= 0 && idx == 41 + abort_at) begin
            rst = 1'b1;
            in_valid[inst] = 1'b1;
            in_data[inst] = job_word(idx);
            @(negedge clk);
            check_quiet(inst, "rst_load");
            rst = 1'b0;
            in_valid[inst] = 1'b0;
            return;
         end
         gate = (mode == 0) ? ($urandom_range(0, 3) != 0) : (t % 2 == 0);
         in_valid[inst] = gate;
         in_data[inst]  = gate ? job_word(idx) : $urandom;
         if (gate && in_ready[inst]) idx++;
         t++;
      end
      check_val("load_count", 32'(idx), 32'(NJOB));
      @(negedge clk);
      in_valid[inst] = 1'b0;
   endtask

   task automatic wait_start(input int inst);
      int t = 0;
      while (!start[inst] && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_val("start_rise", 32'(start[inst]), 1);
   endtask

   task automatic check_mem(input int inst);
      for (int a = 0; a < 41; a++)   check_val($sformatf("pmem[%0d]", a), pmem[inst][a], jp[a]);
      for (int a = 0; a < 1024; a++) check_val($sformatf("smem[%0d]", a), smem[inst][a], js[a]);
   endtask

   task automatic run_check(input int inst, input int n);
      int hi = 0;
      while (start[inst] && hi < 5000) begin
         hi++;
         @(negedge clk);
      end
      check_val("start_high", 32'(hi), 32'(n));
      check_val("cycles", cycles[inst], 32'(n));
   endtask

   task automatic unload(input int inst, input int stall_at);
      int n = 0;
      int t = 0;
      int stall_left = 7;
      int extra = 0;
      while (n < exp_q.size() && t < 20000) begin
         @(negedge clk);
         t++;
         if (n == stall_at && stall_left > 0 && (out_valid[inst] || stall_left < 7)) begin
            out_ready[inst] = 1'b0;
            check_val("stall_valid", 32'(out_valid[inst]), 1);
            check_val("stall_data", out_data[inst], exp_q[n]);
            stall_left--;
         end else begin
            out_ready[inst] = ($urandom_range(0, 3) != 0);
            if (out_valid[inst] && out_ready[inst]) begin
               check_val($sformatf("out[%0d]", n), out_data[inst], exp_q[n]);
               n++;
            end
         end
      end
      check_val("out_count", 32'(n), 32'(exp_q.size()));
      out_ready[inst] = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (out_valid[inst]) extra++;
      end
      check_val("out_extra", 32'(extra), 0);
      check_val("idle_busy", 32'(busy[inst]), 0);
      check_val("idle_in_ready", 32'(in_ready[inst]), 1);
      out_ready[inst] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         in_valid[i]  = 1'b0;
         in_data[i]   = 32'd0;
         out_ready[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check_quiet(i, "reset");
         check_val("reset_out_valid", 32'(out_valid[i]), 0);
         check_val("reset_out_data", out_data[i], 0);
         check_val("reset_cycles", cycles[i], 0);
         check_val("reset_addra", 32'(addra[i]), 0);
         check_val("reset_dina", dina[i], 0);
      end
      rst = 1'b0;

      // Reference job, 50-cycle core run, backpressure on word 5.
      make_job(1'b1);
      done_at[0] = 50;
      load_job(0, 0, -1);
      wait_start(0);
      check_mem(0);
      run_check(0, 50);
      build_exp(1'b1);
      unload(0, 5);

      // Alternating in_valid with junk on idle cycles.
      make_job(1'b0);
      done_at[0] = int'($urandom_range(2, 120));
      load_job(0, 1, -1);
      wait_start(0);
      check_val("cost_at_40", pmem[0][40], jp[40]);
      check_val("s_last", smem[0][1023], js[1023]);
      check_mem(0);
      run_check(0, done_at[0]);
      build_exp(1'b1);
      unload(0, -1);

      // Reset mid LOAD_S, then mid RUN, then a clean job from address 0.
      make_job(1'b0);
      load_job(0, 0, 500);
      make_job(1'b0);
      done_at[0] = 1000;
      load_job(0, 0, -1);
      wait_start(0);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_quiet(0, "rst_run");
      rst = 1'b0;
      make_job(1'b0);
      done_at[0] = int'($urandom_range(2, 80));
      load_job(0, 0, -1);
      wait_start(0);
      check_mem(0);
      run_check(0, done_at[0]);
      build_exp(1'b1);
      unload(0, -1);

      // P-only unload with done on the first RUN cycle.
      make_job(1'b0);
      done_at[1] = 1;
      load_job(1, 0, -1);
      wait_start(1);
      check_mem(1);
      run_check(1, 1);
      build_exp(1'b0);
      unload(1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
      $fatal(1);
   end

endmodule
